// File: rtl/door_pkg.sv
// rtl/door_pkg.sv - channel indices and reset values shared by the door sensor conditioner
package door_pkg;

  localparam int NUM_CH = 7;

  localparam int CH_PA = 0;
  localparam int CH_PP = 1;
  localparam int CH_MO = 2;
  localparam int CH_R  = 3;
  localparam int CH_L  = 4;
  localparam int CH_M  = 5;
  localparam int CH_LK = 6;

  // Lock resets high so the door stays locked until lk_raw is proven low.
  localparam logic [NUM_CH-1:0] RST_Q = 7'b1000000;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - one channel: 2-flop synchroniser plus debounce counter
// Optional SENSOR_GLITCH_CNT_EN adds the rejected-glitch strobe.
module sensor_debounce #(
  parameter int   DEB_CYCLES = 4,
  parameter int   CNT_W      = 8,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic q,
  output logic q_nxt
`ifdef SENSOR_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // The stable level itself is held by the caller; this block only decides its next value.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = '0;
    if (s2 != q) begin
      if (cnt == TERM) begin
        q_nxt = ~q;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

`ifdef SENSOR_GLITCH_CNT_EN
  assign glitch = (s2 == q) && (cnt != '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= RST_VAL;
      s2  <= RST_VAL;
      cnt <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/door_sensor_conditioner.sv
// rtl/door_sensor_conditioner.sv - debounce, pa hold stretch, mo edge pulse and sticky limit fault
// Optional SENSOR_GLITCH_CNT_EN adds the saturating glitch_cnt output.
module door_sensor_conditioner
  import door_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pa_raw,
  input  logic       pp_raw,
  input  logic       mo_raw,
  input  logic       r_raw,
  input  logic       l_raw,
  input  logic       m_raw,
  input  logic       lk_raw,
  output logic       pa_q,
  output logic       pp_q,
  output logic       mo_q,
  output logic       r_q,
  output logic       l_q,
  output logic       m_q,
  output logic       lk_q,
  output logic       mo_rise,
  output logic       limit_fault
`ifdef SENSOR_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  logic [NUM_CH-1:0] raw_v;
  logic [NUM_CH-1:0] q_v;
  logic [NUM_CH-1:0] q_nxt_v;
  logic [15:0]       h;
  logic [15:0]       h_nxt;

  assign raw_v = {lk_raw, m_raw, l_raw, r_raw, mo_raw, pp_raw, pa_raw};

`ifdef SENSOR_GLITCH_CNT_EN
  logic [NUM_CH-1:0] glitch_v;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W),
      .RST_VAL   (RST_Q[i])
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_v[i]),
      .q    (q_v[i]),
      .q_nxt(q_nxt_v[i])
`ifdef SENSOR_GLITCH_CNT_EN
      ,
      .glitch(glitch_v[i])
`endif
    );
  end

  assign pp_q = q_v[CH_PP];
  assign mo_q = q_v[CH_MO];
  assign r_q  = q_v[CH_R];
  assign l_q  = q_v[CH_L];
  assign m_q  = q_v[CH_M];
  assign lk_q = q_v[CH_LK];

  always_comb begin
    h_nxt = '0;
    if (q_v[CH_PA]) begin
      h_nxt = 16'(HOLD_CYCLES);
    end else if (h != '0) begin
      h_nxt = h - 16'd1;
    end
  end

  // Derived outputs use next-state values so they line up with the debounced levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_v         <= RST_Q;
      h           <= '0;
      pa_q        <= 1'b0;
      mo_rise     <= 1'b0;
      limit_fault <= 1'b0;
    end else begin
      q_v         <= q_nxt_v;
      h           <= h_nxt;
      pa_q        <= q_nxt_v[CH_PA] | (h_nxt != '0);
      mo_rise     <= q_nxt_v[CH_MO] & ~q_v[CH_MO];
      limit_fault <= limit_fault | (q_nxt_v[CH_R] & (q_nxt_v[CH_L] | q_nxt_v[CH_M]));
    end
  end

`ifdef SENSOR_GLITCH_CNT_EN
  logic [8:0] gsum;

  always_comb begin
    gsum = {1'b0, glitch_cnt};
    for (int i = 0; i < NUM_CH; i++) begin
      gsum = gsum + 9'(glitch_v[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= (gsum > 9'd255) ? 8'hFF : gsum[7:0];
    end
  end
`endif

endmodule
